// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - round-robin shared run-length detector for NCH serial channels
// Optional macro SEQ_DETECT_ARBITER_MATCH_COUNT_EN adds per-channel saturating match counters.
module seq_detect_arbiter #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 4,
  parameter int CW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] grant,
  output logic [NCH-1:0] z,
  output logic           busy
`ifdef SEQ_DETECT_ARBITER_MATCH_COUNT_EN
  ,
  output logic [NCH*8-1:0] match_cnt
`endif
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  gidx;
  logic [PW-1:0]  next_ptr;
  logic           any_grant;
  logic [NCH-1:0] eligible;

  logic [CW-1:0]  run_cnt [NCH];
  logic [NCH-1:0] last_bit;

  logic [CW-1:0]  sel_cnt;
  logic           sel_last;
  logic           sel_bit;
  logic [CW-1:0]  new_cnt;
  logic           new_z;

  // Reset is folded into eligibility so grant/busy drop the moment rst rises.
  always_comb begin
    eligible = req & ~clr;
    if (rst) begin
      eligible = '0;
    end
  end

  always_comb begin
    int idx;
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!any_grant && eligible[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  assign busy = any_grant;

  always_comb begin
    next_ptr = gidx + 1'b1;
    if (gidx == PW'(NCH - 1)) begin
      next_ptr = '0;
    end
  end

  // Single compare/increment datapath, muxed onto the granted channel.
  always_comb begin
    sel_cnt  = run_cnt[gidx];
    sel_last = last_bit[gidx];
    sel_bit  = bit_in[gidx];
    new_cnt  = CW'(1);
    if (sel_cnt != '0 && sel_bit == sel_last) begin
      if (sel_cnt >= RUN_MAX) begin
        new_cnt = RUN_MAX;
      end else begin
        new_cnt = sel_cnt + 1'b1;
      end
    end
    new_z = (new_cnt == RUN_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      last_bit <= '0;
      z        <= '0;
      for (int i = 0; i < NCH; i++) begin
        run_cnt[i] <= '0;
      end
    end else begin
      if (any_grant) begin
        ptr <= next_ptr;
      end
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          run_cnt[i]  <= '0;
          last_bit[i] <= 1'b0;
          z[i]        <= 1'b0;
        end else if (grant[i]) begin
          run_cnt[i]  <= new_cnt;
          last_bit[i] <= sel_bit;
          z[i]        <= new_z;
        end
      end
    end
  end

`ifdef SEQ_DETECT_ARBITER_MATCH_COUNT_EN
  logic [7:0] mcnt [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          mcnt[i] <= '0;
        end else if (grant[i] && !z[i] && new_z && mcnt[i] != 8'hFF) begin
          mcnt[i] <= mcnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      match_cnt[i*8 +: 8] = mcnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb/tb_seq_detect_arbiter.sv - table-driven bench for seq_detect_arbiter
module tb_seq_detect_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] clr;
  logic [3:0] grant;
  logic [3:0] z;
  logic       busy;
`ifdef SEQ_DETECT_ARBITER_MATCH_COUNT_EN
  logic [31:0] match_cnt;
`endif

  seq_detect_arbiter #(.NCH(4), .RUN_LEN(4), .CW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .bit_in (bit_in),
    .clr    (clr),
    .grant  (grant),
    .z      (z),
    .busy   (busy)
`ifdef SEQ_DETECT_ARBITER_MATCH_COUNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       do_rst;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] clr;
    logic [3:0] exp_grant;
    logic       exp_busy;
    logic [3:0] exp_z;
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] g, input logic bz,
                     input logic [3:0] zz);
    vec_t v;
    v.do_rst    = r;
    v.req       = rq;
    v.bit_in    = b;
    v.clr       = c;
    v.exp_grant = g;
    v.exp_busy  = bz;
    v.exp_z     = zz;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] zz;
    passed = 0;
    total  = 0;

    // ch0 alone: 1,1,1,1 then a fifth 1 (saturation)
    for (int i = 0; i < 5; i++) add(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, (i >= 3) ? 4'b0001 : 4'b0000);
    // ch1 alone: 0,0,0,1 then 1,1,1 -> match only after restart
    for (int i = 0; i < 3; i++) add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 4'b0001);
    for (int i = 0; i < 4; i++) add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, (i == 3) ? 4'b0011 : 4'b0001);
    // req=0101 with ptr=2; ch0 receives a 0, breaking its run
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1, 4'b0011);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1, 4'b0010);
    // ch2 to run_cnt=3, clear alongside req, then restart
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 4'b0010);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 4'b0010);
    add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 4'b0010);
    for (int i = 0; i < 4; i++) add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, (i == 3) ? 4'b0110 : 4'b0010);
    // fairness after reset, 16 cycles of all-request with all-ones data
    for (int c = 0; c < 16; c++) begin
      g  = 4'b0001 << (c % 4);
      zz = (c < 12) ? 4'b0000 : 4'((1 << (c - 11)) - 1);
      add((c == 0), 4'b1111, 4'b1111, 4'b0000, g, 1, zz);
    end
    // clr drops a standing match
    add(0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 0, 4'b0111);

    rst = 1'b1; req = '0; bit_in = '0; clr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_z", 32'(z), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].do_rst) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      req    = vecs[i].req;
      bit_in = vecs[i].bit_in;
      clr    = vecs[i].clr;
      #1;
      check($sformatf("row%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      @(posedge clk);
      #1;
      check($sformatf("row%0d_z", i), 32'(z), 32'(vecs[i].exp_z));
    end

`ifdef SEQ_DETECT_ARBITER_MATCH_COUNT_EN
    check("match_cnt_before_reset", match_cnt, 32'h00010101);
`endif

    // asynchronous reset between edges with requests pending
    @(negedge clk);
    req = 4'b1111; bit_in = 4'b1111; clr = 4'b0000;
    #1;
    check("pre_reset_grant", 32'(grant), 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_z", 32'(z), 32'h0);
    check("async_reset_grant", 32'(grant), 32'h0);
    check("async_reset_busy", 32'(busy), 32'h0);
`ifdef SEQ_DETECT_ARBITER_MATCH_COUNT_EN
    check("async_reset_match_cnt", match_cnt, 32'h0);
`endif
    @(negedge clk);
    req = '0; bit_in = '0;
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
